// File: rtl/pipe_pkg.sv
// Shared constants and entry type for the IF/ID instruction queue.
package pipe_pkg;

    localparam int DW = 32;
    localparam logic [DW-1:0] INS_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [DW-1:0] pc4;
        logic [DW-1:0] ins;
    } ifq_entry_t;

endpackage

// File: rtl/pipe_ifid_queue_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID queue.
interface pipe_ifid_queue_if
    import pipe_pkg::*;
#(
    parameter int AW = 2,
    parameter int QW = DW
);

    logic          if_valid;
    logic [QW-1:0] if_pc4;
    logic [QW-1:0] if_ins;
    logic          if_ready;
    logic          id_ready;
    logic          id_valid;
    logic [QW-1:0] id_pc4;
    logic [QW-1:0] id_ins;
    logic          flush;
    logic [AW:0]   count;

    // The pipeline (fetch, decode, redirect control) drives the queue.
    modport master (
        output if_valid, if_pc4, if_ins, id_ready, flush,
        input  if_ready, id_valid, id_pc4, id_ins, count
    );

    modport slave (
        input  if_valid, if_pc4, if_ins, id_ready, flush,
        output if_ready, id_valid, id_pc4, id_ins, count
    );

endinterface

// File: rtl/pipe_ifq_mem.sv
// Queue storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module pipe_ifq_mem
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = $bits(ifq_entry_t)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is deliberately left out of reset; stale words are never
    // visible because the head is gated by count, and resetting it would cost a
    // reset net on every storage bit. Non-blocking <= keeps the write ordered
    // against the same-edge read of the old head.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_ifid_queue.sv
// IF/ID decoupling queue: buffers {pc4, ins} from fetch, presents them in order to decode,
// drops everything on flush. Optional same-cycle bypass when empty: define QUEUE_BYPASS_EN.
module pipe_ifid_queue
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int QW    = DW
) (
    input  logic               clock,
    input  logic               resetn,
    pipe_ifid_queue_if.slave   q
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count_q;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            bypass;
    logic [2*QW-1:0] head;

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_COUNT);
    assign q.if_ready = ~full;
    assign q.count    = count_q;
    assign pop        = ~empty & q.id_ready;

`ifdef QUEUE_BYPASS_EN
    assign bypass = empty & q.if_valid & ~q.flush;
`else
    assign bypass = 1'b0;
`endif

    // A full queue still takes the incoming word when the head leaves on the same
    // edge; a bypassed word consumed by decode is never written.
    assign push = q.if_valid & (~full | pop) & ~(bypass & q.id_ready);

    pipe_ifq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (2*QW)
    ) u_mem (
        .clock   (clock),
        .we      (push & ~q.flush),
        .wr_addr (wr_ptr),
        .wr_data ({q.if_pc4, q.if_ins}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (q.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // NOTE: every output gets a default before any condition so no latch is inferred.
    always_comb begin
        q.id_valid = ~empty;
        q.id_pc4   = '0;
        q.id_ins   = INS_NOP;
        if (!empty) begin
            q.id_pc4 = head[2*QW-1:QW];
            q.id_ins = head[QW-1:0];
        end
`ifdef QUEUE_BYPASS_EN
        if (bypass) begin
            q.id_valid = 1'b1;
            q.id_pc4   = q.if_pc4;
            q.id_ins   = q.if_ins;
        end
`endif
    end

endmodule
